// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - pipeline hazard detect, operand forwarding select and memory-wait freeze
module hazard_fwd_unit #(
  parameter int REG_W       = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fwd_en,
  input  logic             move,
  input  logic             two_src_ID,
  input  logic [REG_W-1:0] src1_ID,
  input  logic [REG_W-1:0] src2_ID,
  input  logic             wb_en_EXE,
  input  logic             mem_r_en_EXE,
  input  logic [REG_W-1:0] dest_EXE,
  input  logic             wb_en_MEM,
  input  logic [REG_W-1:0] dest_MEM,
  input  logic             wb_en_WB,
  input  logic [REG_W-1:0] dest_WB,
  input  logic [REG_W-1:0] src1_EXE,
  input  logic [REG_W-1:0] src2_EXE,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             hazard,
  output logic             freeze,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] frz_cnt;

  logic m1_exe, m2_exe, m1_mem, m2_mem;

  // Full-width compares; register 0 is an ordinary register here.
  assign m1_exe = wb_en_EXE & (src1_ID == dest_EXE);
  assign m2_exe = wb_en_EXE & two_src_ID & (src2_ID == dest_EXE);
  assign m1_mem = wb_en_MEM & (src1_ID == dest_MEM);
  assign m2_mem = wb_en_MEM & two_src_ID & (src2_ID == dest_MEM);

  always_comb begin
    hazard = 1'b0;
    if (!move) begin
      if (fwd_en) hazard = mem_r_en_EXE & (m1_exe | m2_exe);
      else        hazard = m1_exe | m2_exe | m1_mem | m2_mem;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (!fwd_en)                           return 2'b00;
    else if (wb_en_MEM && src == dest_MEM) return 2'b01;
    else if (wb_en_WB && src == dest_WB)   return 2'b10;
    else                                   return 2'b00;
  endfunction

  assign sel_src1 = fwd_sel(src1_EXE);
  assign sel_src2 = fwd_sel(src2_EXE);

  // Gated by rst_n so a pending request cannot freeze the pipe while in reset.
  assign freeze = rst_n & ~mem_ready & ((state == ST_RUN && mem_req) || state == ST_MEM_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      frz_cnt   <= '0;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        ST_RUN:      if (mem_req && !mem_ready) state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (mem_ready) state <= ST_RUN;
      endcase

      // Run-length counter saturates at the threshold so it never wraps back below it.
      if (freeze) begin
        if (frz_cnt != TIMEOUT_VAL) frz_cnt <= frz_cnt + CNT_ONE;
      end else begin
        frz_cnt <= '0;
      end

      if (cnt_clr) begin
        stall_cnt <= '0;
        timeout   <= 1'b0;
      end else begin
        if ((hazard || freeze) && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
        if (freeze && frz_cnt >= TIMEOUT_VAL - CNT_ONE) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - self-checking bench for hazard_fwd_unit (two parameter sets)
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, fwd_en, move, two_src_ID;
  logic [3:0] src1_ID, src2_ID, dest_EXE, dest_MEM, dest_WB, src1_EXE, src2_EXE;
  logic       wb_en_EXE, mem_r_en_EXE, wb_en_MEM, wb_en_WB, mem_req, mem_ready, cnt_clr;

  logic        hazard_a, freeze_a, timeout_a;
  logic [1:0]  sel1_a, sel2_a;
  logic [15:0] stall_cnt_a;
  logic        hazard_b, freeze_b, timeout_b;
  logic [1:0]  sel1_b, sel2_b;
  logic [2:0]  stall_cnt_b;

  hazard_fwd_unit #(.REG_W(4), .CNT_W(16), .TIMEOUT_CYC(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .move(move), .two_src_ID(two_src_ID),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .wb_en_EXE(wb_en_EXE), .mem_r_en_EXE(mem_r_en_EXE),
    .dest_EXE(dest_EXE), .wb_en_MEM(wb_en_MEM), .dest_MEM(dest_MEM), .wb_en_WB(wb_en_WB),
    .dest_WB(dest_WB), .src1_EXE(src1_EXE), .src2_EXE(src2_EXE), .mem_req(mem_req),
    .mem_ready(mem_ready), .cnt_clr(cnt_clr), .hazard(hazard_a), .freeze(freeze_a),
    .sel_src1(sel1_a), .sel_src2(sel2_a), .stall_cnt(stall_cnt_a), .timeout(timeout_a)
  );

  hazard_fwd_unit #(.REG_W(4), .CNT_W(3), .TIMEOUT_CYC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .move(move), .two_src_ID(two_src_ID),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .wb_en_EXE(wb_en_EXE), .mem_r_en_EXE(mem_r_en_EXE),
    .dest_EXE(dest_EXE), .wb_en_MEM(wb_en_MEM), .dest_MEM(dest_MEM), .wb_en_WB(wb_en_WB),
    .dest_WB(dest_WB), .src1_EXE(src1_EXE), .src2_EXE(src2_EXE), .mem_req(mem_req),
    .mem_ready(mem_ready), .cnt_clr(cnt_clr), .hazard(hazard_b), .freeze(freeze_b),
    .sel_src1(sel1_b), .sel_src2(sel2_b), .stall_cnt(stall_cnt_b), .timeout(timeout_b)
  );

  typedef struct {
    bit       fe, mv, ts;
    bit [3:0] s1id, s2id;
    bit       wbe, mre;
    bit [3:0] de;
    bit       wbm;
    bit [3:0] dm;
    bit       wbw;
    bit [3:0] dw, s1e, s2e;
    bit       exp_h;
    bit [1:0] exp_s1, exp_s2;
  } vec_t;

  vec_t vecs[13];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding-access flag, freeze run length, stall totals.
  bit       m_wait;
  int       m_frz_run, m_sc_a, m_sc_b;
  bit       m_to;
  bit       e_h, e_f;
  bit [1:0] e_s1, e_s2;
  bit       got_f_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit [1:0] fwd_pick(input logic [3:0] s);
    if (!fwd_en) return 2'b00;
    if (wb_en_MEM && s == dest_MEM) return 2'b01;
    if (wb_en_WB && s == dest_WB) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_comb();
    bit r1e, r2e, r1m, r2m;
    r1e = wb_en_EXE && src1_ID == dest_EXE;
    r2e = wb_en_EXE && two_src_ID && src2_ID == dest_EXE;
    r1m = wb_en_MEM && src1_ID == dest_MEM;
    r2m = wb_en_MEM && two_src_ID && src2_ID == dest_MEM;
    if (move)        e_h = 1'b0;
    else if (fwd_en) e_h = mem_r_en_EXE && (r1e || r2e);
    else             e_h = r1e || r2e || r1m || r2m;
    e_s1 = fwd_pick(src1_EXE);
    e_s2 = fwd_pick(src2_EXE);
    e_f  = rst_n && !mem_ready && (m_wait || mem_req);
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_frz_run = 0; m_sc_a = 0; m_sc_b = 0; m_to = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    model_comb();
    chk("hazard_a", 32'(hazard_a), 32'(e_h));
    chk("hazard_b", 32'(hazard_b), 32'(e_h));
    chk("sel_src1", 32'(sel1_a), 32'(e_s1));
    chk("sel_src2", 32'(sel2_a), 32'(e_s2));
    chk("sel_b", 32'({sel1_b, sel2_b}), 32'({e_s1, e_s2}));
    chk("freeze_a", 32'(freeze_a), 32'(e_f));
    chk("freeze_b", 32'(freeze_b), 32'(e_f));
    got_f_a = freeze_a;
    @(posedge clk);
    #1;
    m_wait    = e_f;
    m_frz_run = e_f ? m_frz_run + 1 : 0;
    if (cnt_clr) begin
      m_sc_a = 0; m_sc_b = 0; m_to = 1'b0;
    end else begin
      if (e_h || e_f) begin
        if (m_sc_a < 65535) m_sc_a++;
        if (m_sc_b < 7) m_sc_b++;
      end
      if (m_frz_run >= 4) m_to = 1'b1;
    end
    chk("stall_cnt_a", 32'(stall_cnt_a), 32'(m_sc_a));
    chk("stall_cnt_b", 32'(stall_cnt_b), 32'(m_sc_b));
    chk("timeout_a", 32'(timeout_a), 32'(m_to));
    chk("timeout_b", 32'(timeout_b), 32'(m_to));
  endtask

  task automatic quiet_inputs();
    fwd_en = 1'b0; move = 1'b0; two_src_ID = 1'b0;
    src1_ID = 4'd1; src2_ID = 4'd2; dest_EXE = 4'd3; dest_MEM = 4'd4; dest_WB = 4'd5;
    src1_EXE = 4'd6; src2_EXE = 4'd7;
    wb_en_EXE = 1'b0; mem_r_en_EXE = 1'b0; wb_en_MEM = 1'b0; wb_en_WB = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0,1'b0,1'b0,4'd3,4'd0,1'b0,1'b0,4'd9,1'b1,4'd3,1'b0,4'd0,4'd3,4'd1,1'b1,2'd0,2'd0};
    vecs[1]  = '{1'b0,1'b1,1'b0,4'd3,4'd0,1'b0,1'b0,4'd9,1'b1,4'd3,1'b0,4'd0,4'd3,4'd1,1'b0,2'd0,2'd0};
    vecs[2]  = '{1'b1,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,4'd7,1'b1,4'd5,1'b1,4'd5,4'd5,4'd1,1'b0,2'd1,2'd0};
    vecs[3]  = '{1'b1,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,4'd7,1'b0,4'd5,1'b1,4'd5,4'd5,4'd1,1'b0,2'd2,2'd0};
    vecs[4]  = '{1'b1,1'b0,1'b1,4'd2,4'd7,1'b1,1'b1,4'd7,1'b0,4'd5,1'b1,4'd5,4'd5,4'd1,1'b1,2'd2,2'd0};
    vecs[5]  = '{1'b1,1'b0,1'b1,4'd2,4'd7,1'b1,1'b0,4'd7,1'b0,4'd5,1'b1,4'd5,4'd5,4'd1,1'b0,2'd2,2'd0};
    vecs[6]  = '{1'b1,1'b0,1'b0,4'd4,4'd0,1'b0,1'b0,4'd9,1'b1,4'd4,1'b0,4'd0,4'd1,4'd2,1'b0,2'd0,2'd0};
    vecs[7]  = '{1'b0,1'b0,1'b0,4'd1,4'd6,1'b1,1'b0,4'd6,1'b0,4'd9,1'b0,4'd0,4'd1,4'd2,1'b0,2'd0,2'd0};
    vecs[8]  = '{1'b0,1'b0,1'b1,4'd1,4'd6,1'b1,1'b0,4'd6,1'b0,4'd9,1'b0,4'd0,4'd1,4'd2,1'b1,2'd0,2'd0};
    vecs[9]  = '{1'b0,1'b0,1'b0,4'd0,4'd5,1'b1,1'b0,4'd0,1'b0,4'd9,1'b0,4'd9,4'd1,4'd2,1'b1,2'd0,2'd0};
    vecs[10] = '{1'b1,1'b0,1'b0,4'd1,4'd2,1'b0,1'b0,4'd9,1'b1,4'd8,1'b1,4'd0,4'd8,4'd0,1'b0,2'd1,2'd2};
    vecs[11] = '{1'b1,1'b0,1'b0,4'd1,4'd2,1'b0,1'b0,4'd9,1'b0,4'd8,1'b0,4'd8,4'd8,4'd8,1'b0,2'd0,2'd0};
    vecs[12] = '{1'b1,1'b1,1'b1,4'd7,4'd7,1'b1,1'b1,4'd7,1'b0,4'd9,1'b0,4'd9,4'd1,4'd2,1'b0,2'd0,2'd0};

    // Reset with a pending memory request: freeze must stay low.
    quiet_inputs();
    rst_n = 1'b0; mem_req = 1'b1;
    model_reset();
    #1;
    chk("reset_freeze", 32'(freeze_a), 32'd0);
    chk("reset_stall", 32'(stall_cnt_a), 32'd0);
    chk("reset_timeout", 32'(timeout_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_req = 1'b0;

    foreach (vecs[i]) begin
      fwd_en = vecs[i].fe; move = vecs[i].mv; two_src_ID = vecs[i].ts;
      src1_ID = vecs[i].s1id; src2_ID = vecs[i].s2id;
      wb_en_EXE = vecs[i].wbe; mem_r_en_EXE = vecs[i].mre; dest_EXE = vecs[i].de;
      wb_en_MEM = vecs[i].wbm; dest_MEM = vecs[i].dm;
      wb_en_WB = vecs[i].wbw; dest_WB = vecs[i].dw;
      src1_EXE = vecs[i].s1e; src2_EXE = vecs[i].s2e;
      step();
      chk($sformatf("vec%0d_hazard", i), 32'(hazard_a), 32'(vecs[i].exp_h));
      chk($sformatf("vec%0d_sel1", i), 32'(sel1_a), 32'(vecs[i].exp_s1));
      chk($sformatf("vec%0d_sel2", i), 32'(sel2_a), 32'(vecs[i].exp_s2));
    end

    // Three-cycle memory wait then completion.
    quiet_inputs();
    clear_counts();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("wait%0d_freeze", k), 32'(got_f_a), 32'd1);
    end
    mem_ready = 1'b1;
    step();
    chk("wait_done_freeze", 32'(got_f_a), 32'd0);
    chk("wait_stall_cnt", 32'(stall_cnt_a), 32'd3);
    mem_req = 1'b0; mem_ready = 1'b0;
    step();
    chk("wait_back_in_run", 32'(got_f_a), 32'd0);

    // Timeout after four consecutive freeze edges, sticky until cnt_clr.
    clear_counts();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("timeout_edge%0d", k), 32'(timeout_a), (k >= 4) ? 32'd1 : 32'd0);
    end
    mem_req = 1'b0; mem_ready = 1'b1;
    step();
    chk("timeout_sticky", 32'(timeout_a), 32'd1);
    clear_counts();
    chk("timeout_cleared", 32'(timeout_a), 32'd0);
    chk("stall_cleared", 32'(stall_cnt_a), 32'd0);

    // Saturation of the 3-bit counter under a held hazard.
    mem_ready = 1'b0;
    src1_ID = 4'd3; dest_EXE = 4'd3; wb_en_EXE = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("sat_stall_b", 32'(stall_cnt_b), 32'd7);
    chk("sat_stall_a", 32'(stall_cnt_a), 32'd10);

    // Asynchronous reset in the middle of a memory wait.
    quiet_inputs();
    mem_req = 1'b1; mem_ready = 1'b0;
    step(); step();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_freeze", 32'(freeze_a), 32'd0);
    chk("async_rst_stall_a", 32'(stall_cnt_a), 32'd0);
    chk("async_rst_stall_b", 32'(stall_cnt_b), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_req = 1'b0;
    step();
    chk("resume_in_run", 32'(got_f_a), 32'd0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      fwd_en       = 1'($urandom);
      move         = ($urandom_range(0, 5) == 0);
      two_src_ID   = 1'($urandom);
      src1_ID      = 4'($urandom_range(0, 3));
      src2_ID      = 4'($urandom_range(0, 3));
      dest_EXE     = 4'($urandom_range(0, 3));
      dest_MEM     = 4'($urandom_range(0, 3));
      dest_WB      = 4'($urandom_range(0, 3));
      src1_EXE     = 4'($urandom_range(0, 3));
      src2_EXE     = 4'($urandom_range(0, 3));
      wb_en_EXE    = 1'($urandom);
      mem_r_en_EXE = 1'($urandom);
      wb_en_MEM    = 1'($urandom);
      wb_en_WB     = 1'($urandom);
      mem_req      = 1'($urandom);
      mem_ready    = (i < 200) ? 1'($urandom) : ($urandom_range(0, 4) == 0);
      cnt_clr      = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
